// File: rtl/ex_p2s_fifo_if.sv
// ex_p2s_fifo_if: command queue and serial frame bus of the p2s transmitter
interface ex_p2s_fifo_if #(parameter int ADDR_W = 8, DATA_W = 8, DEPTH = 4);
    logic                   cmd;
    logic                   rnw;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_W-1:0]      data_in;
    logic                   busy;
    logic [$clog2(DEPTH):0] level;
    logic                   drop;
    logic                   sdata;
    logic                   svalid;
    logic                   sdone;
    modport master (output cmd, rnw, addr, data_in, input busy, level, drop, sdata, svalid, sdone);
    modport slave (input cmd, rnw, addr, data_in, output busy, level, drop, sdata, svalid, sdone);
endinterface

// File: rtl/ex_p2s_fifo.sv
// ex_p2s_fifo: queued commands serialised MSB-first as preamble/rnw/addr/field/CRC frames
module ex_p2s_fifo #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 4,
    parameter int                PRE_W     = 4,
    parameter logic [PRE_W-1:0]  PREAMBLE  = 4'hA,
    parameter logic [DATA_W-1:0] RD_FILLER = 8'h5A,
    parameter int                CRC_W     = 4,
    parameter logic [CRC_W-1:0]  CRC_POLY  = 4'h3,
    parameter logic [CRC_W-1:0]  CRC_INIT  = 4'hF,
    parameter int                GAP       = 0
) (
    input logic         clk,
    input logic         rst_n,
    ex_p2s_fifo_if.slave bus
);
    localparam int EW = 1 + ADDR_W + DATA_W;
    localparam int PW = PRE_W + EW;
    localparam int F  = PW + CRC_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(F);
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
    state_t state, state_n;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [PW-1:0]    sh;
    logic [CRC_W-1:0] crc, crc_upd;
    logic [CW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [AW:0]      level_n;
    logic             push, pop, last, fb;

    assign push    = bus.cmd && !bus.busy;
    assign last    = bit_cnt == CW'(F - 1);
    assign fb      = sh[PW-1] ^ crc[CRC_W-1];
    assign crc_upd = {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    assign level_n = bus.level + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {bus.rnw, bus.addr, bus.rnw ? RD_FILLER : bus.data_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wp        <= '0;
            rp        <= '0;
            sh        <= '0;
            crc       <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            bus.level <= '0;
            bus.busy  <= 1'b0;
            bus.drop  <= 1'b0;
        end else begin
            state     <= state_n;
            bus.level <= level_n;
            bus.busy  <= level_n == (AW+1)'(DEPTH);
            bus.drop  <= bus.cmd && bus.busy;
            gap_cnt   <= state == S_GAP ? gap_cnt + GW'(1) : '0;
            if (push) wp <= wp + AW'(1);
            if (pop) begin
                rp      <= rp + AW'(1);
                sh      <= {PREAMBLE, mem[rp]};
                crc     <= CRC_INIT;
                bit_cnt <= '0;
            end else if (state == S_SHIFT) begin
                sh      <= sh << 1;
                bit_cnt <= bit_cnt + CW'(1);
                // preamble leaves the CRC alone; once payload is done the CRC itself is shifted out
                crc     <= bit_cnt < CW'(PRE_W) ? crc : bit_cnt < CW'(PW) ? crc_upd : crc << 1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        bus.sdata  = 1'b0;
        bus.svalid = 1'b0;
        bus.sdone  = 1'b0;
        case (state)
            S_IDLE: begin
                pop     = |bus.level;
                state_n = pop ? S_SHIFT : S_IDLE;
            end
            S_SHIFT: begin
                bus.svalid = 1'b1;
                bus.sdata  = bit_cnt < CW'(PW) ? sh[PW-1] : crc[CRC_W-1];
                bus.sdone  = last;
                if (last) begin
                    pop     = GAP == 0 && |bus.level;
                    state_n = GAP > 0 ? S_GAP : pop ? S_SHIFT : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GW'(GAP - 1)) begin
                    pop     = |bus.level;
                    state_n = pop ? S_SHIFT : S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule

// File: doc/ex_p2s_fifo.md
Name: ex_p2s_fifo

Overview:
Parametrised parallel-to-serial frame transmitter and successor to the two-slot p2s converter. User commands (rnw, addr, data) are queued in a DEPTH-entry FIFO. Each entry is serialised MSB-first as a frame of preamble, rnw, addr, data/filler and CRC, with an optional idle gap between frames. It sits between the register-access master and the serial link PHY.

Parameters:
ADDR_W, 8, address field width
DATA_W, 8, data field width
DEPTH, 4, FIFO entries (power of 2, >=2)
PRE_W, 4, preamble width
PREAMBLE, 4'hA, preamble value, sent MSB-first
RD_FILLER, 8'h5A, value sent in the data field when rnw=1 (DATA_W wide)
CRC_W, 4, CRC width
CRC_POLY, 4'h3, CRC polynomial without the implicit top bit (x^4+x+1)
CRC_INIT, 4'hF, CRC seed loaded at frame start
GAP, 0, idle cycles forced between frames (0 = back-to-back)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd  in  1  command strobe, one cycle per command
rnw  in  1  1 = read, 0 = write; sampled with cmd
addr  in  ADDR_W  address; sampled with cmd
data_in  in  DATA_W  write data; sampled with cmd, ignored when rnw=1
busy  out  1  FIFO full; cmd is not accepted
level  out  $clog2(DEPTH)+1  FIFO occupancy
drop  out  1  one-cycle pulse when cmd arrives while busy
sdata  out  1  serial data
svalid  out  1  high while sdata carries a frame bit
sdone  out  1  high during the last bit (CRC LSB) of each frame

Behaviour:
- Reset is async: all outputs and state clear immediately (sdata=0, svalid=0, sdone=0, busy=0, level=0, drop=0).
  - FIFO is emptied, FSM returns to IDLE.
  - A frame in progress is aborted, not resumed.
- Frame length F = PRE_W+1+ADDR_W+DATA_W+CRC_W (25 by default).
- Bit order: PREAMBLE, rnw, addr, field, CRC. Every field is sent MSB-first.
  - field = RD_FILLER when rnw=1, else data_in.
- Push: at a posedge with cmd=1 and busy=0, {rnw, addr, field} is written to the FIFO.
  - cmd=1 with busy=1: the command is discarded, drop=1 the next cycle, and FIFO/level are unchanged.
  - A push is refused while full even if a pop happens in the same cycle.
  - Push and pop in the same cycle with 0<level<DEPTH leaves level unchanged.
- busy = (level==DEPTH), registered consistently with level.
- FSM states:
  - IDLE: sdata=0, svalid=0. At a posedge with level>0: pop the head entry into the shift register, load CRC = CRC_INIT, set bit_cnt=0, go to SHIFT.
  - SHIFT: svalid=1 and sdata = current bit. bit_cnt increments each cycle.
    - Preamble bits do not affect the CRC.
    - For each of the 1+ADDR_W+DATA_W payload bits b: fb = b ^ crc[CRC_W-1]; crc = (crc<<1) ^ (fb ? CRC_POLY : 0).
    - The final CRC is then shifted out MSB-first. It does not update during output.
  - At bit_cnt==F-1: sdone=1.
    - If GAP>0: next state GAP.
    - Else if level>0: pop and reload the next frame with no idle cycle.
    - Else: IDLE.
  - GAP: sdata=0, svalid=0 for exactly GAP cycles, then behave as IDLE.
- Latency: cmd accepted at edge N with FIFO empty and FSM idle -> FIFO pop at edge N+1 -> first preamble bit on sdata during cycle N+1..N+2, last bit at cycle N+F.
- Entries are transmitted in push order. No reordering, and no entry is lost except by drop.
- A push during SHIFT never disturbs the frame in flight.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH inclusive.
- Illegal FSM encodings recover to IDLE.

Test Plan:
- Single write rnw=0, addr=8'h00, data_in=8'h00 -> 25 svalid cycles with bits 1010_0_00000000_00000000_1001 (CRC 4'h9), sdone on the 25th, then IDLE with sdata=0.
- Read rnw=1, addr=8'h3C, data_in=8'hFF -> data field on sdata is 8'h5A, not 8'hFF. CRC matches the bench model computed over 1_00111100_01011010.
- 6 cmds on consecutive cycles, DEPTH=4, GAP=0 -> first pops at once; level peaks at 4 with busy=1; exactly 1 drop pulse; 5 frames back-to-back with no idle bit, in push order.
- GAP=3, 2 queued commands -> exactly 3 cycles of svalid=0/sdata=0 between the two frames' sdone and first preamble bit.
- rst_n asserted asynchronously mid-frame (bit 12) with level=2 -> sdata/svalid drop immediately; level=0, busy=0. After release, a new cmd produces a clean full frame.
- Pointer wrap: 3*DEPTH+1 commands interleaved with transmission, never overflowing -> all frames correct in order, drop never asserted, level returns to 0.
